// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single-port DFF memory (IDLE/ACCESS/RESP).
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (A wins ties).
module mem_arb #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q;
  logic                win_b_q;   // winner of the access in flight
  logic                last_b_q;  // last granted port, 1 = B
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_we_q;
  logic                a_gnt_q, b_gnt_q;
  logic                a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

  logic                pick_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    pick_b = b_req && !a_req;
`else
    pick_b = b_req && (!a_req || !last_b_q);
`endif
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      mem_we_q   <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;

      // Memory data for the read issued in ACCESS is valid during RESP.
      if (state_q == StResp && !we_q) begin
        if (win_b_q) begin
          b_rdata_q  <= mem_rdata;
          b_rvalid_q <= 1'b1;
        end else begin
          a_rdata_q  <= mem_rdata;
          a_rvalid_q <= 1'b1;
        end
      end

      if (state_q == StAccess) begin
        state_q <= StResp;
      end else if (a_req || b_req) begin
        state_q  <= StAccess;
        win_b_q  <= pick_b;
        last_b_q <= pick_b;
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        mem_we_q <= sel_we;
        a_gnt_q  <= !pick_b;
        b_gnt_q  <= pick_b;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, memory word-address width (8 words).
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req / b_req  input  1  requester A/B access request, level, held until grant.
REQ-006 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read; stable while req is high.
REQ-007 SHALL have ports a_addr / b_addr  input  ADDR_W  word address; stable while req is high.
REQ-008 SHALL have ports a_wdata / b_wdata  input  DATA_W  write data; stable while req is high.
REQ-009 SHALL have ports a_gnt / b_gnt  output  1  one-cycle pulse: request accepted this cycle.
REQ-010 SHALL have ports a_rvalid / b_rvalid  output  1  one-cycle pulse: read data valid.
REQ-011 SHALL have ports a_rdata / b_rdata  output  DATA_W  read data, held until that port's next rvalid.
REQ-012 SHALL have ports mem_addr  output  ADDR_W, mem_we  output  1, mem_wdata  output  DATA_W  drive to the DFF memory.
REQ-013 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_addr is presented.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; every access occupies exactly one ACCESS and one RESP cycle.
REQ-016 SHALL move IDLE->ACCESS on a clock edge with a_req or b_req high, latching winner, we, addr, wdata.
REQ-017 SHALL move ACCESS->RESP unconditionally and RESP->ACCESS if any req is high at that edge (new arbitration), else RESP->IDLE.
REQ-018 SHALL, in ACCESS, drive mem_addr/mem_wdata from latched values, mem_we = latched we, and pulse the winner's gnt.
REQ-019 SHALL hold mem_we = 0 in IDLE and RESP; mem_we high only in ACCESS.
REQ-020 SHALL, for a read, register mem_rdata into winner's rdata at the RESP->next edge and pulse rvalid the following cycle (read latency req-seen-to-rvalid = 3 edges); writes produce no rvalid.
REQ-021 SHALL arbitrate round-robin: single requester wins; both requesting -> the port not granted last wins.
REQ-022 SHALL ignore a requester's req in the cycle its gnt is high (requester drops or re-presents req after gnt).
REQ-023 SHALL never grant both ports in the same cycle; rvalid of one port never asserts for the other port's read.
REQ-024 SHALL wrap no addresses: mem_addr is passed through unmodified, full ADDR_W width.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, all gnt/rvalid 0, rdata 0, busy 0, last-grant pointer = B (so A wins the first tie).
REQ-026 SHALL abort an in-flight access on reset mid-operation with no write committed after rst_n falls and no rvalid issued.
REQ-027 SHALL resume arbitration on the first rising edge after rst_n rises.

Configuration
REQ-028 SHALL, with macro MEM_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority: A always wins a tie.
REQ-029 SHALL, without MEM_ARB_FIXED_PRIO_EN, use round-robin per REQ-021; all other behaviour identical.

Verification
REQ-030 SHALL cover: A writes 16'h1253 to addr 7, then A reads addr 7 -> mem_we high one cycle with mem_addr 7; a_rvalid pulses with a_rdata 16'h1253.
REQ-031 SHALL cover: A and B both request continuously (reads, addr 1 and 2) -> grants alternate A,B,A,B; each rvalid carries its own address's data.
REQ-032 SHALL cover: same as previous with MEM_ARB_FIXED_PRIO_EN -> only A granted while a_req stays high; B starves.
REQ-033 SHALL cover: rst_n pulled low during ACCESS of a B write of 16'hBEEF to addr 3 -> mem_we drops at once, no b_gnt/b_rvalid afterwards, addr 3 unchanged.
REQ-034 SHALL cover: B alone issues back-to-back reads addr 0..7 -> busy stays high, one grant every 2 cycles, 8 rvalid pulses in order, then IDLE and busy low.
